binarize_cfg_ctrl: RTL and testbench
====================================

# binarize_cfg_ctrl

Frame-synchronous configuration controller for the HDMI binarization pipeline. Sits in the `pix_clk` domain between the user-control logic and `video_display`. It accepts threshold/mode change requests through a req/ack handshake and holds each request in a shadow register. It commits the request only at a frame boundary (vsync rising edge), so a frame is never rendered with mixed settings. It also provides an optional automatic threshold sweep that steps the threshold every `FRAME_DIV` frames in a ping-pong pattern.

## Interface
Parameters:
- `FRAME_DIV`, 16'd60: frames between sweep steps; legal range 1..65535.
- `TH_DEFAULT`, 8'd128: threshold after reset.
- `TH_STEP`, 8'd8: sweep increment; legal range 1..255.

Ports:
- `pix_clk` input 1: pixel clock; the single clock of the block.
- `rstn` input 1: reset; asynchronous, active-low.
- `vs_in` input 1: vertical sync from the timing generator; active-high, synchronous to `pix_clk`.
- `cfg_req` input 1: configuration request; sampled only while `busy`=0.
- `cfg_mode` input 2: requested mode; 0 = colour bypass, 1 = grey, 2 = binary, 3 = inverted binary.
- `cfg_th` input 8: requested threshold.
- `sweep_en` input 1: enables the automatic threshold sweep.
- `cfg_ack` output 1: one-cycle pulse confirming that a request was committed.
- `busy` output 1: high while a request is pending.
- `thr_out` output 8: active threshold fed to the datapath.
- `mode_out` output 2: active mode fed to the datapath.
- `frame_cnt` output 16: free-running frame counter.

## Operation
- Frame edge: `vs_q` is `vs_in` registered once. `fe = vs_in & ~vs_q`.
- State machine states: IDLE, PEND, ACK.
  - IDLE: if `cfg_req`=1, latch `cfg_mode` and `cfg_th` into the shadow register, set `busy`=1, and go to PEND.
  - PEND: `cfg_req` and the input buses are ignored. On `fe`, copy the shadow register to `thr_out` and `mode_out`, clear the sweep divider, and go to ACK.
  - ACK: `cfg_ack`=1 for exactly this cycle and `busy`=0. Return to IDLE; a new request is accepted from the next cycle.
- `frame_cnt` increments on every `fe` in all states and wraps 65535→0.
- Sweep runs only when `sweep_en`=1 and the state is IDLE.
  - A 16-bit divider increments on each `fe`.
  - When the divider would reach `FRAME_DIV`, it resets to 0 and the threshold takes one step.
- Sweep step, 8-bit arithmetic with no wrap (direction bit `dir`, 0 = up):
  - Up: if `thr_out` > 255−`TH_STEP`, set `thr_out`=255 and `dir`=1; otherwise add `TH_STEP`.
  - Down: if `thr_out` < `TH_STEP`, set `thr_out`=0 and `dir`=0; otherwise subtract `TH_STEP`.
- `sweep_en`=0 holds the divider at 0; `thr_out` and `dir` keep their values.
- A committed request does not change `dir`.
- Simultaneous events:
  - A request commit on `fe` takes priority over a sweep step on the same `fe`; that sweep step is discarded and the divider is cleared.
  - `cfg_req` arriving on the same cycle as `fe` in IDLE is latched only; it commits on the next `fe`.
  - A sweep step and `frame_cnt` may update on the same cycle.
- Reset mid-operation: any pending request is dropped, no `cfg_ack` is issued, and all outputs take their reset values.

## Timing
- Reset values: `thr_out`=`TH_DEFAULT`, `mode_out`=2, `busy`=0, `cfg_ack`=0, `frame_cnt`=0. Internally: `dir`=0, divider=0, shadow register = defaults, state IDLE.
- Request to `busy`: `busy` rises on the clock edge after the cycle in which `cfg_req` is sampled high.
- Commit latency: `thr_out` and `mode_out` change on the clock edge that samples `fe` = 1. They are therefore valid starting 1 cycle after `vs_in` first goes high.
- `cfg_ack`: high in the cycle immediately after the commit edge, for 1 cycle.
- `busy` falls at the same edge at which `cfg_ack` rises.
- Sweep: the first step occurs on the `FRAME_DIV`-th `fe` after `sweep_en` rises. Later steps occur every `FRAME_DIV` frames.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset defaults:** assert `rstn`=0, release, and run 3 frames with no request. Required: `thr_out`=128, `mode_out`=2, `busy`=0, `frame_cnt`=3.
- **Request handshake:** pulse `cfg_req` with `cfg_th`=0x40 and `cfg_mode`=3 in mid-frame. Required:
  - `busy`=1 the next cycle.
  - Outputs unchanged until vsync, then `thr_out`=0x40 and `mode_out`=3 one cycle after `vs_in` rises.
  - `cfg_ack` is a single-cycle pulse the following cycle.
- **Ignored re-request:** while in PEND, drive `cfg_req`=1 with `cfg_th`=0x10. Required: commit still uses 0x40, and exactly one `cfg_ack` pulse occurs.
- **Ping-pong sweep:** `FRAME_DIV`=2, `TH_STEP`=100, `sweep_en`=1, start threshold 128. Required: `thr_out` sequence 228, 255, 155, 55, 0, 100, with one step every 2 frames.
- **Collision:** a request with `cfg_th`=0x22 commits on the same `fe` that is due a sweep step. Required: `thr_out`=0x22, no step applied, and the next step occurs `FRAME_DIV` frames later.
- **Reset mid-operation:** assert `rstn`=0 while in PEND, then release and run 1 frame. Required: no `cfg_ack`, `thr_out`=128, `busy`=0.

Source files
------------

// File: rtl/binarize_cfg_ctrl.sv
// rtl/binarize_cfg_ctrl.sv - frame-synchronous threshold/mode controller with ping-pong threshold sweep
module binarize_cfg_ctrl #(
  parameter logic [15:0] FRAME_DIV  = 16'd60,
  parameter logic [7:0]  TH_DEFAULT = 8'd128,
  parameter logic [7:0]  TH_STEP    = 8'd8
) (
  input  logic        pix_clk,
  input  logic        rstn,
  input  logic        vs_in,
  input  logic        cfg_req,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  cfg_th,
  input  logic        sweep_en,
  output logic        cfg_ack,
  output logic        busy,
  output logic [7:0]  thr_out,
  output logic [1:0]  mode_out,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        vs_q;
  logic        fe;
  logic        commit;
  logic        step_due;
  logic [7:0]  sh_th_q, sh_th_d;
  logic [1:0]  sh_mode_q, sh_mode_d;
  logic [7:0]  thr_q, thr_d;
  logic [1:0]  mode_q, mode_d;
  logic        dir_q, dir_d;
  logic [15:0] div_q, div_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        ack_q, busy_q;

  assign fe       = vs_in & ~vs_q;
  assign step_due = (div_q == FRAME_DIV - 16'd1);

  always_comb begin
    state_d   = state_q;
    sh_th_d   = sh_th_q;
    sh_mode_d = sh_mode_q;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_req) begin
          sh_th_d   = cfg_th;
          sh_mode_d = cfg_mode;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (fe) begin
          commit  = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A commit on a frame edge wins over any sweep step due on that same edge.
  always_comb begin
    thr_d  = thr_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    div_d  = div_q;
    fcnt_d = fe ? fcnt_q + 16'd1 : fcnt_q;
    if (commit) begin
      thr_d  = sh_th_q;
      mode_d = sh_mode_q;
      div_d  = '0;
    end else if (!sweep_en) begin
      div_d = '0;
    end else if ((state_q == ST_IDLE) && fe) begin
      if (step_due) begin
        div_d = '0;
        if (!dir_q) begin
          if (thr_q > (8'd255 - TH_STEP)) begin
            thr_d = 8'd255;
            dir_d = 1'b1;
          end else begin
            thr_d = thr_q + TH_STEP;
          end
        end else begin
          if (thr_q < TH_STEP) begin
            thr_d = 8'd0;
            dir_d = 1'b0;
          end else begin
            thr_d = thr_q - TH_STEP;
          end
        end
      end else begin
        div_d = div_q + 16'd1;
      end
    end
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      vs_q      <= 1'b0;
      sh_th_q   <= TH_DEFAULT;
      sh_mode_q <= 2'd2;
      thr_q     <= TH_DEFAULT;
      mode_q    <= 2'd2;
      dir_q     <= 1'b0;
      div_q     <= '0;
      fcnt_q    <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_in;
      sh_th_q   <= sh_th_d;
      sh_mode_q <= sh_mode_d;
      thr_q     <= thr_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      div_q     <= div_d;
      fcnt_q    <= fcnt_d;
      ack_q     <= (state_d == ST_ACK);
      busy_q    <= (state_d == ST_PEND);
    end
  end

  assign cfg_ack   = ack_q;
  assign busy      = busy_q;
  assign thr_out   = thr_q;
  assign mode_out  = mode_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_binarize_cfg_ctrl.sv
// tb/tb_binarize_cfg_ctrl.sv - directed and randomized checks against a frame-level reference model
module tb_binarize_cfg_ctrl;
  localparam int FD   = 2;
  localparam int STEP = 100;
  localparam int THD  = 128;

  logic        pix_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vs_in = 1'b0;
  logic        cfg_req = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [7:0]  cfg_th = 8'd0;
  logic        sweep_en = 1'b0;
  logic        cfg_ack;
  logic        busy;
  logic [7:0]  thr_out;
  logic [1:0]  mode_out;
  logic [15:0] frame_cnt;

  binarize_cfg_ctrl #(
    .FRAME_DIV (16'(FD)),
    .TH_DEFAULT(8'(THD)),
    .TH_STEP   (8'(STEP))
  ) dut (
    .pix_clk  (pix_clk),
    .rstn     (rstn),
    .vs_in    (vs_in),
    .cfg_req  (cfg_req),
    .cfg_mode (cfg_mode),
    .cfg_th   (cfg_th),
    .sweep_en (sweep_en),
    .cfg_ack  (cfg_ack),
    .busy     (busy),
    .thr_out  (thr_out),
    .mode_out (mode_out),
    .frame_cnt(frame_cnt)
  );

  always #5 pix_clk = ~pix_clk;

  int total = 0;
  int passed = 0;
  int ack_cnt = 0;

  always @(negedge pix_clk) if (cfg_ack === 1'b1) ack_cnt++;

  // Reference model: state changes only at frame edges and requests.
  int m_thr, m_mode, m_dir, m_div, m_fc, m_sh_th, m_sh_mode;
  bit m_pend;

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_thr = THD; m_mode = 2; m_dir = 0; m_div = 0; m_fc = 0;
    m_pend = 0; m_sh_th = THD; m_sh_mode = 2;
  endtask

  task automatic model_fe(output bit committed);
    committed = 0;
    m_fc = (m_fc + 1) % 65536;
    if (m_pend) begin
      m_thr = m_sh_th; m_mode = m_sh_mode; m_div = 0; m_pend = 0;
      committed = 1;
    end else if (sweep_en) begin
      m_div++;
      if (m_div == FD) begin
        m_div = 0;
        if (m_dir == 0) begin
          if (m_thr + STEP > 255) begin m_thr = 255; m_dir = 1; end
          else m_thr = m_thr + STEP;
        end else begin
          if (m_thr - STEP < 0) begin m_thr = 0; m_dir = 0; end
          else m_thr = m_thr - STEP;
        end
      end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".thr"}, thr_out, m_thr);
    chk({tag, ".mode"}, mode_out, m_mode);
    chk({tag, ".fcnt"}, frame_cnt, m_fc);
    chk({tag, ".busy"}, busy, m_pend);
  endtask

  task automatic frame(input int low);
    bit c;
    vs_in = 1'b1;
    tick();
    model_fe(c);
    check_state("fe");
    chk("fe.ack", cfg_ack, c);
    tick();
    chk("ack_clear", cfg_ack, 0);
    tick();
    vs_in = 1'b0;
    repeat (low) tick();
    check_state("mid");
  endtask

  task automatic request(input logic [7:0] th, input logic [1:0] md, input int hold);
    cfg_req = 1'b1; cfg_th = th; cfg_mode = md;
    if (!m_pend) begin m_sh_th = th; m_sh_mode = md; m_pend = 1; end
    repeat (hold) tick();
    cfg_req = 1'b0; cfg_th = 8'($urandom); cfg_mode = 2'($urandom);
    chk("req.busy", busy, 1);
  endtask

  task automatic set_sweep(input bit en);
    sweep_en = en;
    if (!en) m_div = 0;
    tick();
  endtask

  int seq[6] = '{228, 255, 155, 55, 0, 100};
  int a0;
  bit c;

  initial begin
    model_reset();
    repeat (3) tick();
    chk("rst.thr", thr_out, THD);
    chk("rst.mode", mode_out, 2);
    chk("rst.busy", busy, 0);
    chk("rst.ack", cfg_ack, 0);
    chk("rst.fcnt", frame_cnt, 0);
    rstn = 1'b1;
    repeat (5) tick();
    repeat (3) frame(6);
    chk("dflt.fcnt", frame_cnt, 3);
    chk("dflt.thr", thr_out, 128);

    // request handshake plus ignored re-request while pending
    request(8'h40, 2'd3, 1);
    repeat (4) tick();
    chk("pend.thr_hold", thr_out, 128);
    chk("pend.mode_hold", mode_out, 2);
    request(8'h10, 2'd0, 2);
    a0 = ack_cnt;
    frame(5);
    chk("commit.thr", thr_out, 8'h40);
    chk("commit.mode", mode_out, 3);
    chk("commit.ack_pulses", ack_cnt - a0, 1);

    // ping-pong sweep from 128
    request(8'd128, 2'd2, 1);
    frame(4);
    set_sweep(1'b1);
    for (int i = 0; i < 12; i++) begin
      frame(4);
      if (i % 2 == 1) chk("sweep.seq", thr_out, seq[i/2]);
    end

    // commit collides with a due sweep step
    frame(4);
    request(8'h22, 2'd1, 1);
    frame(4);
    chk("coll.thr", thr_out, 8'h22);
    frame(4);
    chk("coll.hold", thr_out, 8'h22);
    frame(4);
    chk("coll.next_step", thr_out, 8'h22 + STEP);

    // request on the same cycle as the frame edge is only latched
    set_sweep(1'b0);
    vs_in = 1'b1; cfg_req = 1'b1; cfg_th = 8'h5A; cfg_mode = 2'd1;
    tick();
    model_fe(c);
    m_sh_th = 8'h5A; m_sh_mode = 1; m_pend = 1;
    cfg_req = 1'b0;
    check_state("samecyc");
    tick(); tick();
    vs_in = 1'b0;
    repeat (4) tick();
    frame(4);
    chk("samecyc.commit", thr_out, 8'h5A);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0)
        request(8'($urandom), 2'($urandom), int'($urandom_range(1, 3)));
      if ($urandom_range(0, 3) == 0) set_sweep(~sweep_en);
      frame(int'($urandom_range(2, 8)));
    end

    // reset while pending drops the request
    request(8'h77, 2'd0, 1);
    repeat (3) tick();
    a0 = ack_cnt;
    rstn = 1'b0;
    tick();
    chk("rstmid.thr", thr_out, THD);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.ack", cfg_ack, 0);
    tick();
    rstn = 1'b1;
    model_reset();
    set_sweep(1'b0);
    frame(4);
    chk("rstmid.no_ack", ack_cnt - a0, 0);
    chk("rstmid.thr_after", thr_out, 128);
    chk("rstmid.busy_after", busy, 0);
    chk("rstmid.fcnt", frame_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
